clk_ratio_monitor: RTL

Clock-domain monitor that receives a divided clock, e.g. a ripple divider output, as an ordinary asynchronous input and measures it in the `clk` domain. It synchronises the input, measures period and high time in `clk` cycles, and compares the period against an expected ratio. It raises `locked` after a run of consecutive matches and a sticky `err` on loss of lock or timeout. It sits beside the clock divider as its on-chip checker.

---
 rtl/clk_ratio_monitor.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/clk_ratio_monitor.sv
// clk_ratio_monitor: measures an asynchronous divided clock (mon_in) in the
// clk domain. It reports the period and high time, raises locked after LOCK_N
// consecutive periods equal to `expected`, and sets a sticky err on loss of
// lock or on timeout.
// Optional feature macro: CLK_MON_DUTY_EN. When it is defined, the monitor
// also checks duty cycle while locked. When it is undefined, there is no
// high-time counter and high_time is tied to 0.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | disabled or just reset; counters held at zero
// ST_WAIT    | armed, discarding the partial period up to the first rise
// ST_MEASURE | every rise closes a full period and produces a valid pulse
module clk_ratio_monitor #(
  parameter int CNT_W  = 8,
  parameter int LOCK_N = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mon_in,
  input  logic [CNT_W-1:0] expected,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             err
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [3:0]       LOCK_V  = 4'(LOCK_N);

  state_t           state, state_nxt;
  logic             s_meta, s, s_d, rise;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       match_cnt;
  logic [4:0]       match_inc;
  logic             timeout, meas_evt, match, duty_bad, err_set;

  // two-flop synchroniser plus a delay flop for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_meta <= 1'b0;
      s      <= 1'b0;
      s_d    <= 1'b0;
    end else begin
      s_meta <= mon_in;
      s      <= s_meta;
      s_d    <= s;
    end
  end

  assign rise = s & ~s_d;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // next-state logic; disabling the monitor always returns it to idle
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    state_nxt = ST_WAIT;
        ST_WAIT:    if (rise) state_nxt = ST_MEASURE;
        ST_MEASURE: if (timeout) state_nxt = ST_WAIT;
        default:    state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: a timeout or a completed-period event for this cycle
  always_comb begin
    timeout  = 1'b0;
    meas_evt = 1'b0;
    if (enable && (state != ST_IDLE)) begin
      timeout  = !rise && (cnt == CNT_MAX);
      meas_evt = rise && (state == ST_MEASURE);
    end
  end

  // period counter; a rise restarts it at 1 so that it holds the full period at the next rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          cnt <= '0;
    else if (!enable || state == ST_IDLE) cnt <= '0;
    else if (rise)                      cnt <= 1'b1;
    else if (timeout)                   cnt <= '0;
    else                                cnt <= cnt + 1'b1;
  end

`ifdef CLK_MON_DUTY_EN
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W+1:0] dbl, per;
  localparam logic [CNT_W+1:0] ONE_W = 1;

  // high-time counter; the rise cycle itself is high, so it also starts at 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          hcnt <= '0;
    else if (!enable || state == ST_IDLE) hcnt <= '0;
    else if (rise)                      hcnt <= 1'b1;
    else if (timeout)                   hcnt <= '0;
    else if (s)                         hcnt <= hcnt + 1'b1;
  end

  // duty check: twice the high time must be within +/-1 of the period
  always_comb begin
    dbl      = {1'b0, hcnt, 1'b0};
    per      = {2'b00, cnt};
    duty_bad = !(((dbl + ONE_W) >= per) && (dbl <= (per + ONE_W)));
  end

  // capture the high time together with the period
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         high_time <= '0;
    else if (meas_evt) high_time <= hcnt;
  end
`else
  assign duty_bad  = 1'b0;
  assign high_time = '0;
`endif

  assign match     = (expected != '0) && (cnt == expected);
  assign match_inc = {1'b0, match_cnt} + 5'd1;
  assign err_set   = timeout ||
                     (meas_evt && locked && (!match || duty_bad));

  // capture the period and pulse valid one cycle after the closing rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= meas_evt;
      if (meas_evt) period <= cnt;
    end
  end

  // lock tracking; any mismatch, duty violation, timeout or disable drops lock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_cnt <= '0;
      locked    <= 1'b0;
    end else if (!enable || timeout) begin
      match_cnt <= '0;
      locked    <= 1'b0;
    end else if (meas_evt) begin
      if (!match || (locked && duty_bad)) begin
        match_cnt <= '0;
        locked    <= 1'b0;
      end else begin
        if (match_cnt < LOCK_V) match_cnt <= match_inc[3:0];
        if (match_inc >= {1'b0, LOCK_V}) locked <= 1'b1;
      end
    end
  end

  // sticky error; a set event takes priority over err_clr in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

endmodule
